// File: rtl/calc_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_entry_ctrl : keypad entry and operator sequencer for the calc ALU.  |
// | Optional macro AUTO_EQUALS_EN: operator key in ENTRY_B implies equals.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_entry_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_MAG       = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  input  logic [16:0] answer,
  input  logic        ovw,
  output logic [16:0] V1,
  output logic [16:0] V2,
  output logic [1:0]  opcode,
  output logic        newop,
  output logic        result_valid,
  output logic        entry_ovf,
  output logic        error
);

  localparam int                CNT_W      = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [19:0]       MAG_LIMIT  = 20'(MAX_MAG);

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_MUL = 4'hB;
  localparam logic [3:0] KEY_SUB = 4'hC;
  localparam logic [3:0] KEY_EQU = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_NEG = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_OP      = 3'd1,
    ST_ENTRY_B = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [16:0]      v1_q, v1_d;
  logic [16:0]      v2_q, v2_d;
  logic [1:0]       opcode_q, opcode_d;
  logic             newop_q, newop_d;
  logic             result_valid_q, result_valid_d;
  logic             entry_ovf_q, entry_ovf_d;
  logic             error_q, error_d;
  logic             key_ready_q, key_ready_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             auto_pend_q, auto_pend_d;
  logic [1:0]       auto_op_q, auto_op_d;

  logic             key_acc;
  logic             is_digit;
  logic             is_op;
  logic [1:0]       key_opc;
  logic [19:0]      digit_mag;
  logic [16:0]      fresh_v1;

  always_comb begin
    key_acc   = key_valid && key_ready_q;
    is_digit  = (key_code <= 4'd9);
    is_op     = (key_code == KEY_ADD) || (key_code == KEY_MUL) || (key_code == KEY_SUB);
    case (key_code)
      KEY_MUL: key_opc = 2'b01;
      KEY_SUB: key_opc = 2'b10;
      default: key_opc = 2'b00;
    endcase
    digit_mag = ({4'd0, v1_q[15:0]} * 20'd10) + {16'd0, key_code};
    // A digit typed with no entry in progress starts a fresh positive operand.
    fresh_v1  = {13'd0, key_code};
  end

  always_comb begin
    state_d        = state_q;
    v1_d           = v1_q;
    v2_d           = v2_q;
    opcode_d       = opcode_q;
    newop_d        = 1'b0;
    result_valid_d = 1'b0;
    entry_ovf_d    = 1'b0;
    auto_pend_d    = auto_pend_q;
    auto_op_d      = auto_op_q;
    settle_cnt_d   = (settle_cnt_q == SETTLE_MAX) ? settle_cnt_q : settle_cnt_q + CNT_W'(1);

    case (state_q)
      ST_ENTRY_A, ST_ENTRY_B: begin
        if (key_acc) begin
          if (is_digit) begin
            if (digit_mag > MAG_LIMIT) begin
              entry_ovf_d = 1'b1;
            end else begin
              v1_d = {v1_q[16], digit_mag[15:0]};
            end
          end else if (key_code == KEY_NEG) begin
            if (v1_q[15:0] != 16'd0) begin
              v1_d[16] = ~v1_q[16];
            end
          end else if (is_op) begin
            if (state_q == ST_ENTRY_A) begin
              v2_d         = v1_q;
              v1_d         = '0;
              opcode_d     = key_opc;
              newop_d      = 1'b1;
              settle_cnt_d = '0;
              state_d      = ST_OP;
            end else begin
`ifdef AUTO_EQUALS_EN
              auto_pend_d = 1'b1;
              auto_op_d   = key_opc;
              state_d     = ST_WAIT;
`endif
            end
          end else if ((key_code == KEY_EQU) && (state_q == ST_ENTRY_B)) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_OP: begin
        if (key_acc) begin
          if (is_digit) begin
            v1_d    = fresh_v1;
            state_d = ST_ENTRY_B;
          end else if (key_code == KEY_NEG) begin
            v1_d    = '0;
            state_d = ST_ENTRY_B;
          end else if (is_op) begin
            opcode_d     = key_opc;
            newop_d      = 1'b1;
            settle_cnt_d = '0;
          end
        end
      end

      ST_WAIT: begin
        // The operator pipeline only reflects the current opcode once settled.
        if (settle_cnt_q == SETTLE_MAX) begin
          if (ovw) begin
            auto_pend_d = 1'b0;
            state_d     = ST_ERROR;
          end else begin
            v2_d           = answer;
            v1_d           = '0;
            result_valid_d = 1'b1;
            state_d        = ST_RESULT;
          end
        end
      end

      ST_RESULT: begin
        if (auto_pend_q) begin
          opcode_d     = auto_op_q;
          newop_d      = 1'b1;
          settle_cnt_d = '0;
          auto_pend_d  = 1'b0;
          state_d      = ST_OP;
        end else if (key_acc) begin
          if (is_digit) begin
            v2_d    = '0;
            v1_d    = fresh_v1;
            state_d = ST_ENTRY_A;
          end else if (is_op) begin
            v1_d         = '0;
            opcode_d     = key_opc;
            newop_d      = 1'b1;
            settle_cnt_d = '0;
            state_d      = ST_OP;
          end
        end
      end

      ST_ERROR: begin
      end

      default: begin
        state_d = ST_ENTRY_A;
      end
    endcase

    // Clear wins over everything; key_ready is never high in WAIT.
    if (key_acc && (key_code == KEY_CLR)) begin
      v1_d        = '0;
      v2_d        = '0;
      auto_pend_d = 1'b0;
      state_d     = ST_ENTRY_A;
    end

    key_ready_d = (state_d != ST_WAIT) && !auto_pend_d;
    error_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_ENTRY_A;
      v1_q           <= '0;
      v2_q           <= '0;
      opcode_q       <= 2'b00;
      newop_q        <= 1'b0;
      result_valid_q <= 1'b0;
      entry_ovf_q    <= 1'b0;
      error_q        <= 1'b0;
      key_ready_q    <= 1'b1;
      settle_cnt_q   <= SETTLE_MAX;
      auto_pend_q    <= 1'b0;
      auto_op_q      <= 2'b00;
    end else begin
      state_q        <= state_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      opcode_q       <= opcode_d;
      newop_q        <= newop_d;
      result_valid_q <= result_valid_d;
      entry_ovf_q    <= entry_ovf_d;
      error_q        <= error_d;
      key_ready_q    <= key_ready_d;
      settle_cnt_q   <= settle_cnt_d;
      auto_pend_q    <= auto_pend_d;
      auto_op_q      <= auto_op_d;
    end
  end

  assign V1           = v1_q;
  assign V2           = v2_q;
  assign opcode       = opcode_q;
  assign newop        = newop_q;
  assign result_valid = result_valid_q;
  assign entry_ovf    = entry_ovf_q;
  assign error        = error_q;
  assign key_ready    = key_ready_q;

endmodule
`default_nettype wire

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Keypad-side front end that drives the calculator arithmetic unit's operand/operator interface.
- Turns single-cycle key events into:
  - decimal operand entry, held as 17-bit sign-magnitude;
  - operand staging on V1/V2;
  - an opcode plus a one-cycle newop pulse.
- Waits for the arithmetic unit's two-register operator pipeline to settle, then latches answer/ovw as a result or an error.
- Sits between the keypad decoder and the arithmetic unit; its outputs connect directly to that unit's inputs.

Parameters:
- SETTLE_CYCLES, 2: clock edges after a newop pulse before answer is valid for the new opcode.
- MAX_MAG, 65535: largest magnitude accepted during digit entry.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  0-9 digit, A add, B multiply, C subtract, D equals, E clear, F negate.
- key_ready  out  1  high when a key event is accepted; low in WAIT.
- answer  in  17  sign-magnitude result from the arithmetic unit (combinational on V1/V2/opcode).
- ovw  in  1  overflow flag from the arithmetic unit.
- V1  out  17  current entry / second operand, sign-magnitude.
- V2  out  17  first operand / accumulator, sign-magnitude.
- opcode  out  2  00 add, 01 multiply, 10 subtract; held between newop pulses.
- newop  out  1  one-cycle pulse; opcode is valid in the same cycle.
- result_valid  out  1  one-cycle pulse when a result is latched into V2.
- entry_ovf  out  1  one-cycle pulse when a digit is rejected (magnitude would exceed MAX_MAG).
- error  out  1  high while in ERROR.

Behaviour:
- Reset values:
  - V1, V2, opcode: 0.
  - newop, result_valid, entry_ovf, error: 0.
  - key_ready: 1.
  - settle_cnt: SETTLE_CYCLES. settle_cnt is a saturating counter: cleared to 0 on newop, incremented each cycle, saturates at SETTLE_CYCLES.
  - State: ENTRY_A.
- States: ENTRY_A, OP, ENTRY_B, WAIT, RESULT, ERROR.
- Key events are processed only when key_valid && key_ready.
- Digit d in ENTRY_A / ENTRY_B:
  - new magnitude = V1[15:0]*10 + d, computed at 20 bits.
  - If the result is > MAX_MAG: V1 is unchanged and entry_ovf pulses.
  - Sign V1[16] is preserved.
- Negate in ENTRY_A / ENTRY_B:
  - Toggles V1[16].
  - Ignored when V1[15:0]==0, so no negative zero is ever produced.
- Operator key in ENTRY_A or RESULT:
  - V2 <= V1 in ENTRY_A; V2 keeps the result in RESULT.
  - V1 <= 0, opcode <= code, newop pulses, settle_cnt <= 0, next state OP.
- Operator key in OP: replaces opcode, pulses newop again, settle_cnt <= 0, stays in OP.
- Digit or negate in OP: V1 starts from 0, the key is applied, next state ENTRY_B.
- Equals:
  - In ENTRY_B: go to WAIT.
  - In ENTRY_A, OP or RESULT: ignored.
- WAIT:
  - key_ready = 0.
  - When settle_cnt == SETTLE_CYCLES, sample answer/ovw.
  - If ovw: go to ERROR; V1/V2 hold.
  - Otherwise: V2 <= answer, V1 <= 0, result_valid pulses next cycle, go to RESULT.
  - With an already-settled counter, equals acceptance to result_valid is 2 cycles.
- Digit in RESULT: V2 <= 0, V1 <= digit (sign +), go to ENTRY_A.
- Clear in any state except WAIT: V1, V2 <= 0; go to ENTRY_A. opcode is unchanged and no newop is issued.
- ERROR: error=1; all keys except clear are ignored.
- Subtract semantics are fixed by the arithmetic unit as V2 - V1 (first operand minus second).
- Reset asserted mid-WAIT or mid-entry: every register returns to its reset value on the next edge, and no result_valid is issued.

Optional Feature:
- Macro: AUTO_EQUALS_EN.
- Defined: an operator key in ENTRY_B performs an implicit equals.
  - WAIT/latch proceeds as for equals.
  - If there is no error, the controller then issues the new opcode with a newop pulse in the cycle after result_valid and enters OP. V1 is 0 and V2 holds the result.
- Undefined: an operator key in ENTRY_B is ignored.

Test Plan:
- Keys 1,2,A,3,4,D -> V2=12 after A, newop with opcode 00; result_valid with V2=17'h0002E (46); state RESULT.
- Keys 5,C,9,D -> result_valid with V2={1,16'd4} (-4).
- Keys 3,0,0,B,3,0,0,D (arith unit reports ovw=1) -> error=1, result_valid never pulses; key 1 ignored; key E returns to ENTRY_A with V1=V2=0.
- Keys 6,5,5,3,5 then 9 -> entry_ovf pulses and V1 stays 65535. Then F -> V1=17'h1FFFF. Clear, then F on 0 -> V1=0.
- Keys 7,A,2,D back-to-back on consecutive cycles -> key_ready low until settle_cnt reaches 2; answer sampled no earlier than 2 edges after newop; V2=9.
- Reset asserted 1 cycle into WAIT -> next cycle V1=V2=0, state ENTRY_A, result_valid=0. With AUTO_EQUALS_EN: keys 2,A,3,A -> result_valid with V2=5, then newop (opcode 00) on the next cycle.
